// File: rtl/serial_par_rx.sv
// Serial-to-byte receive front end: comma hunt, lock after LOCK_COUNT aligned commas, byte/valid out.
// Optional loss-of-lock detection is compiled in with `define LOSS_OF_LOCK_EN.
module serial_par_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);

    logic [1:0] state_q, state_d;
    logic [7:0] sr_q;
    logic [7:0] window;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q;
    logic       byte_done;
    logic       is_comma;

`ifdef LOSS_OF_LOCK_EN
    localparam logic [7:0] GAP_N = 8'(MAX_GAP);
    logic [7:0] gap_cnt_q, gap_cnt_d;
`endif

    // window is the shift register as it will look after this edge
    assign window    = {sr_q[6:0], data_in};
    assign is_comma  = (window == COMMA);
    assign byte_done = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
`ifdef LOSS_OF_LOCK_EN
        gap_cnt_d   = gap_cnt_q;
`endif
        case (state_q)
            ST_HUNT: begin
                bit_cnt_d = 3'd0;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    state_d     = (LOCK_N == 4'd1) ? ST_LOCKED : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (byte_done) begin
                    if (is_comma) begin
                        if (comma_cnt_q + 4'd1 >= LOCK_N) begin
                            state_d     = ST_LOCKED;
                            comma_cnt_d = LOCK_N;
                        end else begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d     = ST_HUNT;
                        comma_cnt_d = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
`ifdef LOSS_OF_LOCK_EN
                // the byte that hit MAX_GAP was already emitted; drop lock one edge later
                if (gap_cnt_q == GAP_N) begin
                    state_d     = ST_HUNT;
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 4'd0;
                    gap_cnt_d   = 8'd0;
                    data_d      = 8'h00;
                    valid_d     = 1'b0;
                end else
`endif
                if (byte_done) begin
                    data_d  = window;
                    valid_d = !is_comma;
`ifdef LOSS_OF_LOCK_EN
                    if (is_comma)
                        gap_cnt_d = 8'd0;
                    else if (gap_cnt_q != 8'hFF)
                        gap_cnt_d = gap_cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_HUNT;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= window;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= (state_d == ST_LOCKED);
        end
    end

`ifdef LOSS_OF_LOCK_EN
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) gap_cnt_q <= 8'd0;
        else          gap_cnt_q <= gap_cnt_d;
    end
`endif

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_par_rx.sv
// Bench for serial_par_rx: directed and random bit streams checked edge-by-edge against a stream-level model.
module tb_serial_par_rx;

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam int         LOCK_COUNT = 4;
    localparam int         MAX_GAP    = 16;
    localparam int         MAXN       = 2048;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_asrt = 0;
    int n_fail = 0;

    bit         bits[$];
    logic [7:0] exp_d[MAXN];
    logic       exp_v[MAXN];
    logic       exp_a[MAXN];
    logic [7:0] obs_d[MAXN];
    logic       obs_v[MAXN];
    logic       obs_a[MAXN];

    serial_par_rx #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT), .MAX_GAP(MAX_GAP)) dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] x);
        n_asrt++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
    endtask

    task automatic push_rand_bits(input int n);
        for (int i = 0; i < n; i++) bits.push_back(bit'($urandom_range(1)));
    endtask

    // last 8 bits seen at edge e (edge e samples bits[e-1]); zeros before the stream start
    function automatic logic [7:0] win(input int e);
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int j = 0; j < 8; j++) begin
            idx = e - 8 + j;
            w = {w[6:0], (idx >= 0) ? bits[idx] : 1'b0};
        end
        return w;
    endfunction

    // Expected outputs per edge: find a comma, require LOCK_COUNT-1 more on byte
    // boundaries, then emit every 8th window until reset (or a long comma gap).
    function automatic void build_model();
        int n, e, f, k, g;
        logic fail, unl, v;
        logic [7:0] d;
        n = bits.size();
        for (int i = 0; i < MAXN; i++) begin
            exp_d[i] = 8'h00; exp_v[i] = 1'b0; exp_a[i] = 1'b0;
        end
        e = 1;
        while (e <= n) begin
            if (win(e) != COMMA) begin
                e++;
            end else begin
                k = 1; f = e; fail = 1'b0;
                while (k < LOCK_COUNT && f + 8 <= n && !fail) begin
                    f += 8;
                    if (win(f) != COMMA) fail = 1'b1;
                    else k++;
                end
                if (fail) e = f + 1;
                else if (k < LOCK_COUNT) e = n + 1;
                else begin
                    d = 8'h00; v = 1'b0; g = 0; unl = 1'b0; e = n + 1;
                    for (int t = f; t <= n && !unl; t++) begin
                        exp_a[t] = 1'b1;
                        if (t > f && (t - f) % 8 == 0) begin
                            d = win(t);
                            v = (d != COMMA);
                            g = v ? g + 1 : 0;
                        end
                        exp_d[t] = d;
                        exp_v[t] = v;
`ifdef LOSS_OF_LOCK_EN
                        if (g == MAX_GAP) begin
                            unl = 1'b1;
                            e = t + 2;
                        end
`endif
                    end
                end
            end
        end
    endfunction

    // assert reset between edges, check the asynchronous clear, then hold it with junk data
    task automatic do_reset(input string name);
        #3;
        reset_L = 1'b0;
        #1;
        chk({name, " async d"}, data_out, 8'h00);
        chk({name, " async v"}, {7'd0, valid_out}, 8'h00);
        chk({name, " async a"}, {7'd0, active}, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_32f);
            data_in = 1'($urandom_range(1));
            @(posedge clk_32f);
            #1;
            chk($sformatf("%s rst%0d d", name, i), data_out, 8'h00);
            chk($sformatf("%s rst%0d v", name, i), {7'd0, valid_out}, 8'h00);
            chk($sformatf("%s rst%0d a", name, i), {7'd0, active}, 8'h00);
        end
    endtask

    task automatic run_stream(input string name);
        build_model();
        for (int e = 1; e <= bits.size(); e++) begin
            @(negedge clk_32f);
            reset_L = 1'b1;
            data_in = bits[e-1];
            @(posedge clk_32f);
            #1;
            obs_d[e] = data_out; obs_v[e] = valid_out; obs_a[e] = active;
            chk($sformatf("%s e%0d d", name, e), data_out, exp_d[e]);
            chk($sformatf("%s e%0d v", name, e), {7'd0, valid_out}, {7'd0, exp_v[e]});
            chk($sformatf("%s e%0d a", name, e), {7'd0, active}, {7'd0, exp_a[e]});
        end
    endtask

    initial begin
        int lk;

        do_reset("init");

        // aligned lock
        bits.delete();
        repeat (4) push_byte(COMMA);
        push_byte(8'h5A); push_byte(8'hC3);
        run_stream("aligned");
        chk("aligned act31", {7'd0, obs_a[31]}, 8'h00);
        chk("aligned act32", {7'd0, obs_a[32]}, 8'h01);
        chk("aligned d32", obs_d[32], 8'h00);
        chk("aligned d40", obs_d[40], 8'h5A);
        chk("aligned v40", {7'd0, obs_v[40]}, 8'h01);
        chk("aligned d48", obs_d[48], 8'hC3);
        do_reset("aligned");

        // misaligned lock
        bits.delete();
        push_rand_bits(3);
        repeat (4) push_byte(COMMA);
        push_byte(8'h11);
        run_stream("misalign");
        lk = 0;
        for (int e = 1; e <= bits.size() && lk == 0; e++) if (obs_a[e] === 1'b1) lk = e;
        chk("misalign found", {7'd0, (lk != 0)}, 8'h01);
        if (lk != 0 && lk + 8 <= bits.size()) begin
            chk("misalign d", obs_d[lk+8], 8'h11);
            chk("misalign v", {7'd0, obs_v[lk+8]}, 8'h01);
            chk("misalign d7", obs_d[lk+7], 8'h00);
        end
        do_reset("misalign");

        // aborted sync then relock
        bits.delete();
        repeat (3) push_byte(COMMA);
        push_byte(8'h00);
        repeat (4) push_byte(COMMA);
        push_byte(8'h7E);
        run_stream("abort");
        chk("abort act32", {7'd0, obs_a[32]}, 8'h00);
        chk("abort act64", {7'd0, obs_a[64]}, 8'h01);
        chk("abort d72", obs_d[72], 8'h7E);
        chk("abort v72", {7'd0, obs_v[72]}, 8'h01);
        do_reset("abort");

        // comma while locked, then reset mid-byte
        bits.delete();
        repeat (4) push_byte(COMMA);
        push_byte(8'h22); push_byte(COMMA); push_byte(8'h33);
        push_rand_bits(3);
        run_stream("lockcomma");
        chk("lockcomma d48", obs_d[48], 8'hBC);
        chk("lockcomma v48", {7'd0, obs_v[48]}, 8'h00);
        chk("lockcomma d56", obs_d[56], 8'h33);
        chk("lockcomma pre", {7'd0, active}, 8'h01);
        do_reset("lockcomma");

        // random payload with scattered commas
        bits.delete();
        push_rand_bits(5);
        repeat (LOCK_COUNT) push_byte(COMMA);
        for (int i = 0; i < 40; i++)
            push_byte(($urandom_range(3) == 0) ? COMMA : 8'($urandom));
        run_stream("random");
        do_reset("random");

        // long run of payload without commas
        bits.delete();
        repeat (4) push_byte(COMMA);
        repeat (16) push_byte(8'h01);
        push_rand_bits(4);
        run_stream("gap16");
        chk("gap16 d160", obs_d[160], 8'h01);
        chk("gap16 v160", {7'd0, obs_v[160]}, 8'h01);
        chk("gap16 a160", {7'd0, obs_a[160]}, 8'h01);
`ifdef LOSS_OF_LOCK_EN
        chk("gap16 a161", {7'd0, obs_a[161]}, 8'h00);
        chk("gap16 v161", {7'd0, obs_v[161]}, 8'h00);
`else
        chk("gap16 a161", {7'd0, obs_a[161]}, 8'h01);
`endif
        do_reset("gap16");

        bits.delete();
        repeat (4) push_byte(COMMA);
        repeat (15) push_byte(8'h01);
        push_byte(COMMA);
        repeat (15) push_byte(8'h01);
        run_stream("gap15");
        chk("gap15 held", {7'd0, obs_a[bits.size()]}, 8'h01);
        do_reset("gap15");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
